// File: rtl/qoi_buf_arbiter_pkg.sv
// Shared types and window decode for the image/QOI buffer arbiter.
// Defaults put the image buffer at 0x8000 and the QOI buffer at 0x9000, 4 KiB each.
package qoi_buf_pkg;

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_ACC} owner_t;

    typedef logic [12:0] buf_addr_t;

    typedef struct packed {
        logic      hit;
        buf_addr_t addr;
    } win_t;

    localparam logic [15:0] IMG_BASE_DEF  = 16'h8000;
    localparam logic [15:0] QOI_BASE_DEF  = 16'h9000;
    localparam logic [15:0] WIN_SIZE_DEF  = 16'h1000;
    localparam int          MAX_BURST_DEF = 8;

    // The top bound is computed in 17 bits so a window ending at 0xFFFF still decodes.
    function automatic win_t win_decode(input logic [15:0] cpu_ab,
                                        input logic [15:0] img_base = IMG_BASE_DEF,
                                        input logic [15:0] qoi_base = QOI_BASE_DEF,
                                        input logic [15:0] win_size = WIN_SIZE_DEF);
        win_t        w;
        logic [16:0] top;
        logic [15:0] off;
        top   = {1'b0, qoi_base} + {1'b0, win_size};
        w.hit = (cpu_ab >= img_base) && ({1'b0, cpu_ab} < top);
        if (cpu_ab >= qoi_base) begin
            off    = cpu_ab - qoi_base;
            w.addr = {1'b1, off[11:0]};
        end else begin
            off    = cpu_ab - img_base;
            w.addr = {1'b0, off[11:0]};
        end
        return w;
    endfunction

endpackage

// File: rtl/qoi_buf_arbiter_if.sv
// CPU, accelerator and buffer-RAM signals of the buffer arbiter.
// slave is the arbiter side; master is the side driving requests and the RAM read data.
interface qoi_buf_arbiter_if;
    import qoi_buf_pkg::*;

    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;

    logic        acc_req;
    buf_addr_t   acc_addr;
    logic        acc_we;
    logic [7:0]  acc_wdata;
    logic        acc_gnt;
    logic        acc_rvalid;
    logic [7:0]  acc_rdata;

    buf_addr_t   mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport slave (
        input  cpu_ab, cpu_do, cpu_we, acc_req, acc_addr, acc_we, acc_wdata, mem_rdata,
        output cpu_di, cpu_rdy, acc_gnt, acc_rvalid, acc_rdata, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output cpu_ab, cpu_do, cpu_we, acc_req, acc_addr, acc_we, acc_wdata, mem_rdata,
        input  cpu_di, cpu_rdy, acc_gnt, acc_rvalid, acc_rdata, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/qoi_buf_arbiter.sv
// Shares the single-port image/QOI buffers between the 65C02 bus and the QOI accelerator.
// Latency: grant is decided in the same cycle; read data returns the cycle after the grant.
// Backpressure: the CPU is stalled with cpu_rdy=0, the accelerator waits for acc_gnt; bounded bursts.
module qoi_buf_arbiter
    import qoi_buf_pkg::*;
#(
    parameter logic [15:0] IMG_BASE  = IMG_BASE_DEF,
    parameter logic [15:0] QOI_BASE  = QOI_BASE_DEF,
    parameter logic [15:0] WIN_SIZE  = WIN_SIZE_DEF,
    parameter int          MAX_BURST = MAX_BURST_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    qoi_buf_arbiter_if.slave   bus
);

    localparam int                CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_TOP = CNT_W'(MAX_BURST);

    owner_t            last_owner;
    logic [CNT_W-1:0]  burst_cnt;
    logic              rd_pend_cpu;
    logic              rd_pend_acc;
    logic [7:0]        cpu_di_q;
    logic [7:0]        acc_rdata_q;

    win_t              cpu_win;
    owner_t            grant;

    always_comb begin
        cpu_win = win_decode(bus.cpu_ab, IMG_BASE, QOI_BASE, WIN_SIZE);
        grant   = OWN_NONE;
        if (cpu_win.hit && bus.acc_req) begin
            case (last_owner)
                OWN_CPU: grant = OWN_ACC;
                OWN_ACC: grant = (burst_cnt < BURST_TOP) ? OWN_ACC : OWN_CPU;
                default: grant = OWN_CPU;
            endcase
        end else if (cpu_win.hit) begin
            grant = OWN_CPU;
        end else if (bus.acc_req) begin
            grant = OWN_ACC;
        end
        // No access of any kind may leave the block while reset is held.
        if (!reset_n) begin
            grant = OWN_NONE;
        end
    end

    assign bus.cpu_rdy   = !cpu_win.hit || (grant == OWN_CPU) || !reset_n;
    assign bus.acc_gnt   = (grant == OWN_ACC);
    assign bus.mem_we    = ((grant == OWN_CPU) && bus.cpu_we) || ((grant == OWN_ACC) && bus.acc_we);
    assign bus.mem_addr  = (grant == OWN_ACC) ? bus.acc_addr  : cpu_win.addr;
    assign bus.mem_wdata = (grant == OWN_ACC) ? bus.acc_wdata : bus.cpu_do;

    // Read data is forwarded in the return cycle and held afterwards.
    assign bus.cpu_di     = rd_pend_cpu ? bus.mem_rdata : cpu_di_q;
    assign bus.acc_rvalid = rd_pend_acc;
    assign bus.acc_rdata  = rd_pend_acc ? bus.mem_rdata : acc_rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_owner  <= OWN_NONE;
            burst_cnt   <= '0;
            rd_pend_cpu <= 1'b0;
            rd_pend_acc <= 1'b0;
            cpu_di_q    <= 8'h00;
            acc_rdata_q <= 8'h00;
        end else begin
            rd_pend_cpu <= (grant == OWN_CPU) && !bus.cpu_we;
            rd_pend_acc <= (grant == OWN_ACC) && !bus.acc_we;
            if (rd_pend_cpu) begin
                cpu_di_q <= bus.mem_rdata;
            end
            if (rd_pend_acc) begin
                acc_rdata_q <= bus.mem_rdata;
            end
            case (grant)
                OWN_CPU: begin
                    last_owner <= OWN_CPU;
                    burst_cnt  <= '0;
                end
                OWN_ACC: begin
                    last_owner <= OWN_ACC;
                    if (burst_cnt != BURST_TOP) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: begin
                    last_owner <= OWN_NONE;
                    burst_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qoi_buf_arbiter.sv
// Bench for qoi_buf_arbiter: directed scenarios, then randomized CPU/accelerator traffic
// checked every cycle against a behavioural arbitration and memory model.
module tb_qoi_buf_arbiter;
    import qoi_buf_pkg::*;

    localparam int MAXB = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    qoi_buf_arbiter_if bus();

    qoi_buf_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Buffer RAM: one port, one-cycle read latency.
    logic [7:0] ram [8192];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        ram_q <= ram[bus.mem_addr];
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = ram_q;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owned the buffer last and how many ACC beats in a row.
    logic [7:0] exp_mem [8192];
    int         m_last   = 0;     // 0 none, 1 cpu, 2 acc
    int         m_streak = 0;
    bit         m_cpu_pend = 0;
    bit         m_acc_pend = 0;
    logic [7:0] m_cpu_val = 8'h00;
    logic [7:0] m_acc_val = 8'h00;
    logic [7:0] m_cpu_di  = 8'h00;
    bit         last_rdy = 1'b1;
    bit         last_gnt = 1'b0;

    function automatic int pick_winner(bit hit, bit req);
        if (!hit && !req) return 0;
        if (hit && !req)  return 1;
        if (!hit)         return 2;
        if (m_last == 1)  return 2;
        if (m_last == 2 && m_streak < MAXB) return 2;
        return 1;
    endfunction

    always @(negedge clk) begin
        int        win;
        bit        hit;
        logic [12:0] a;
        last_rdy = bus.cpu_rdy;
        last_gnt = bus.acc_gnt;
        if (!reset_n) begin
            check_eq("rst_acc_gnt", 32'(bus.acc_gnt), 0);
            check_eq("rst_mem_we", 32'(bus.mem_we), 0);
            check_eq("rst_cpu_rdy", 32'(bus.cpu_rdy), 1);
            check_eq("rst_acc_rvalid", 32'(bus.acc_rvalid), 0);
            check_eq("rst_cpu_di", 32'(bus.cpu_di), 0);
            check_eq("rst_acc_rdata", 32'(bus.acc_rdata), 0);
            m_last = 0; m_streak = 0; m_cpu_pend = 0; m_acc_pend = 0; m_cpu_di = 8'h00;
        end else begin
            if (m_cpu_pend) m_cpu_di = m_cpu_val;
            check_eq("cpu_di", 32'(bus.cpu_di), 32'(m_cpu_di));
            check_eq("acc_rvalid", 32'(bus.acc_rvalid), 32'(m_acc_pend));
            if (m_acc_pend) check_eq("acc_rdata", 32'(bus.acc_rdata), 32'(m_acc_val));
            m_cpu_pend = 0;
            m_acc_pend = 0;
            hit = (bus.cpu_ab >= 16'h8000) && (bus.cpu_ab < 16'hA000);
            win = pick_winner(hit, bus.acc_req);
            check_eq("cpu_rdy", 32'(bus.cpu_rdy), 32'(!hit || win == 1));
            check_eq("acc_gnt", 32'(bus.acc_gnt), 32'(win == 2));
            check_eq("mem_we", 32'(bus.mem_we),
                     32'((win == 1 && bus.cpu_we) || (win == 2 && bus.acc_we)));
            if (win == 1) begin
                a = 13'(bus.cpu_ab - 16'h8000);
                check_eq("cpu_mem_addr", 32'(bus.mem_addr), 32'(a));
                if (bus.cpu_we) begin
                    check_eq("cpu_wdata", 32'(bus.mem_wdata), 32'(bus.cpu_do));
                    exp_mem[a] = bus.cpu_do;
                end else begin
                    m_cpu_pend = 1; m_cpu_val = exp_mem[a];
                end
                m_last = 1; m_streak = 0;
            end else if (win == 2) begin
                a = bus.acc_addr;
                check_eq("acc_mem_addr", 32'(bus.mem_addr), 32'(a));
                if (bus.acc_we) begin
                    check_eq("acc_wdata", 32'(bus.mem_wdata), 32'(bus.acc_wdata));
                    exp_mem[a] = bus.acc_wdata;
                end else begin
                    m_acc_pend = 1; m_acc_val = exp_mem[a];
                end
                m_last = 2; m_streak++;
            end else begin
                m_last = 0; m_streak = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        bus.cpu_ab = 16'h0000; bus.cpu_we = 1'b0; bus.cpu_do = 8'h00;
    endtask

    logic [15:0] edge_ab [6] = '{16'h7FFF, 16'h8000, 16'h8FFF, 16'h9000, 16'h9FFF, 16'hA000};

    initial begin
        int  stalls;
        int  wcnt;
        bit  done;
        int  dens;
        cpu_idle();
        bus.acc_req = 1'b0; bus.acc_addr = '0; bus.acc_we = 1'b0; bus.acc_wdata = 8'h00;
        for (int i = 0; i < 8192; i++) begin
            ram[i]     = 8'($urandom);
            exp_mem[i] = ram[i];
        end
        ram[5] = 8'h3C; exp_mem[5] = 8'h3C;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // CPU-only read
        bus.cpu_ab = 16'h8005;
        @(negedge clk);
        check_eq("rd_addr", 32'(bus.mem_addr), 32'h005);
        check_eq("rd_rdy", 32'(bus.cpu_rdy), 1);
        check_eq("rd_gnt", 32'(bus.acc_gnt), 0);
        step(); cpu_idle();
        @(negedge clk);
        check_eq("rd_cpu_di", 32'(bus.cpu_di), 32'h3C);
        step();

        // Accelerator-only write burst into the QOI buffer
        for (int i = 0; i < 4; i++) begin
            bus.acc_req = 1'b1; bus.acc_we = 1'b1;
            bus.acc_addr = 13'(32'h1000 + i); bus.acc_wdata = 8'(32'hA0 + i);
            @(negedge clk);
            check_eq("wb_gnt", 32'(bus.acc_gnt), 1);
            check_eq("wb_we", 32'(bus.mem_we), 1);
            check_eq("wb_addr", 32'(bus.mem_addr), 32'h1000 + i);
            step();
        end
        bus.acc_req = 1'b0;
        for (int i = 0; i < 4; i++) check_eq("wb_ram", 32'(ram[32'h1000 + i]), 32'hA0 + i);
        step();

        // Contention: three lone ACC beats, then the CPU waits out the burst limit
        for (int i = 0; i < 3; i++) begin
            bus.acc_req = 1'b1; bus.acc_we = 1'b0; bus.acc_addr = 13'(32'h0100 + i);
            @(negedge clk);
            check_eq("ct_acc_alone", 32'(bus.acc_gnt), 1);
            step();
        end
        bus.cpu_ab = 16'h9010; bus.cpu_we = 1'b0;
        stalls = 0; done = 0;
        for (int i = 0; i < 12 && !done; i++) begin
            @(negedge clk);
            if (bus.cpu_rdy) begin
                done = 1;
                check_eq("ct_cpu_addr", 32'(bus.mem_addr), 32'h1010);
                check_eq("ct_cpu_gnt", 32'(bus.acc_gnt), 0);
            end else begin
                stalls++;
            end
            step();
        end
        check_eq("ct_stalls", 32'(stalls), 5);
        cpu_idle();
        @(negedge clk);
        check_eq("ct_acc_after", 32'(bus.acc_gnt), 1);
        step();
        bus.acc_req = 1'b0;
        step();

        // Simultaneous start from idle
        bus.cpu_ab = 16'h8000; bus.cpu_we = 1'b0;
        bus.acc_req = 1'b1; bus.acc_we = 1'b0; bus.acc_addr = 13'h0110;
        @(negedge clk);
        check_eq("sim_cpu_first", 32'(bus.cpu_rdy), 1);
        check_eq("sim_acc_wait", 32'(bus.acc_gnt), 0);
        step();
        bus.cpu_ab = 16'h8001;
        @(negedge clk);
        check_eq("sim_acc_next", 32'(bus.acc_gnt), 1);
        check_eq("sim_cpu_stall", 32'(bus.cpu_rdy), 0);
        step();
        bus.acc_req = 1'b0;
        @(negedge clk);
        check_eq("sim_cpu_done", 32'(bus.cpu_rdy), 1);
        step(); cpu_idle();
        step();

        // CPU write held off while the accelerator owns the buffer
        bus.acc_req = 1'b1; bus.acc_we = 1'b1; bus.acc_addr = 13'h0120; bus.acc_wdata = 8'h99;
        step();
        bus.cpu_ab = 16'h8020; bus.cpu_we = 1'b1; bus.cpu_do = 8'h55;
        wcnt = 0; done = 0;
        for (int i = 0; i < 15 && !done; i++) begin
            @(negedge clk);
            if (bus.mem_we && bus.mem_addr == 13'h020) begin
                wcnt++;
                check_eq("stw_data", 32'(bus.mem_wdata), 32'h55);
            end
            if (bus.cpu_rdy) done = 1;
            step();
        end
        cpu_idle();
        check_eq("stw_count", 32'(wcnt), 1);
        check_eq("stw_ram", 32'(ram[32]), 32'h55);
        bus.acc_req = 1'b0;
        step();

        // Reset right after a granted accelerator read
        bus.acc_req = 1'b1; bus.acc_we = 1'b0; bus.acc_addr = 13'h0200;
        @(negedge clk);
        check_eq("rr_gnt", 32'(bus.acc_gnt), 1);
        step();
        bus.cpu_ab = 16'h8000; bus.cpu_we = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check_eq("rr_rvalid", 32'(bus.acc_rvalid), 0);
        check_eq("rr_gnt_low", 32'(bus.acc_gnt), 0);
        check_eq("rr_we_low", 32'(bus.mem_we), 0);
        check_eq("rr_rdy_high", 32'(bus.cpu_rdy), 1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        bus.acc_req = 1'b0;
        bus.cpu_ab = 16'h4000; bus.cpu_we = 1'b1;
        @(negedge clk);
        check_eq("nw_rdy", 32'(bus.cpu_rdy), 1);
        check_eq("nw_we", 32'(bus.mem_we), 0);
        check_eq("nw_gnt", 32'(bus.acc_gnt), 0);
        step();

        // Randomized traffic; requesters hold their access until it is accepted
        for (int i = 0; i < 4000; i++) begin
            dens = (i < 2000) ? 90 : 40;
            if (last_rdy) begin
                case ($urandom_range(0, 7))
                    0: bus.cpu_ab = 16'($urandom_range(0, 32'h7FFF));
                    1: bus.cpu_ab = 16'($urandom_range(32'hA000, 32'hFFFF));
                    2: bus.cpu_ab = edge_ab[$urandom_range(0, 5)];
                    default: bus.cpu_ab = 16'(32'h8000 + $urandom_range(0, 32'h1FFF));
                endcase
                bus.cpu_we = 1'($urandom);
                bus.cpu_do = 8'($urandom);
            end
            if (!(bus.acc_req && !last_gnt)) begin
                bus.acc_req   = ($urandom_range(0, 99) < dens);
                bus.acc_addr  = 13'($urandom_range(0, 8191));
                bus.acc_we    = 1'($urandom);
                bus.acc_wdata = 8'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
